// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle for apb_slave_regbank: requester-side signals plus the
// slave's registered response.
interface apb_slave_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  pselx;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslave_error;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslave_error
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslave_error
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB register bank with programmable wait states, error responses, hardware-fed
// read-only registers and a saturating error counter. All outputs are registered.
module apb_slave_regbank #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 8,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = NUM_REGS'(8'hC0),
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb_slave_regbank_if.slave             bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [7:0]                     err_cnt
);
    localparam int unsigned    ADDR_LSB   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned    IDX_W      = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned    SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W + 1)'(NUM_REGS);
    localparam logic [3:0]     WAIT_CNT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    perr_q, perr_d;
    logic                    pready_q;
    logic [7:0]              err_cnt_q;

    logic                    latch;
    logic                    complete;
    logic                    enter_ready;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic                    acc_write;
    logic [IDX_W-1:0]        acc_idx;
    logic [SEL_W-1:0]        acc_sel;
    logic [SEL_W-1:0]        sel_q;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    ro_hit;
    logic                    acc_err;
    logic [DATA_WIDTH-1:0]   rd_value;

    // With zero wait states the response is decoded straight off the setup-phase bus.
    assign acc_addr  = latch ? bus.paddr : addr_q;
    assign acc_write = latch ? bus.pwrite : write_q;
    assign acc_idx   = acc_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign acc_sel   = acc_idx[SEL_W-1:0];
    assign sel_q     = addr_q[ADDR_LSB +: SEL_W];

    if (ADDR_LSB > 0) begin : g_align
        assign misaligned = |acc_addr[ADDR_LSB-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    assign out_of_range = {1'b0, acc_idx} >= NUM_REGS_C;
    assign ro_hit       = RO_MASK[acc_sel];
    assign acc_err      = misaligned | out_of_range | (acc_write & ro_hit);
    assign rd_value     = ro_hit ? status_i[acc_sel*DATA_WIDTH +: DATA_WIDTH] : regs_q[acc_sel];

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        latch    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.pselx && !bus.penable) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = StReady;
                    end else begin
                        state_d = StWait;
                        wcnt_d  = 4'd1;
                    end
                end
            end
            StWait: begin
                if (!bus.pselx) begin
                    state_d = StIdle;
                end else if (wcnt_q == WAIT_CNT) begin
                    state_d = StReady;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            StReady: begin
                if (!bus.pselx) begin
                    state_d = StIdle;
                end else if (bus.penable) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Response is captured once on entry to READY and held until it is left.
        enter_ready = (state_d == StReady) && (state_q != StReady);
        prdata_d    = '0;
        perr_d      = 1'b0;
        if (state_d == StReady) begin
            if (enter_ready) begin
                perr_d   = acc_err;
                prdata_d = acc_err ? '0 : rd_value;
            end else begin
                perr_d   = perr_q;
                prdata_d = prdata_q;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            perr_q    <= 1'b0;
            pready_q  <= 1'b0;
            err_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            prdata_q <= prdata_d;
            perr_q   <= perr_d;
            pready_q <= (state_d == StReady);
            if (latch) begin
                addr_q  <= bus.paddr;
                write_q <= bus.pwrite;
                wdata_q <= bus.pwdata;
            end
            if (complete && perr_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (complete && write_q && !perr_q) begin
                regs_q[sel_q] <= wdata_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
    end

    assign bus.prdata       = prdata_q;
    assign bus.pready       = pready_q;
    assign bus.pslave_error = perr_q;
    assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: a zero-wait and a two-wait instance
// share one APB driver, selected by sel.
module tb_apb_slave_regbank;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
    localparam logic [7:0]  RO = 8'hC0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    logic             psel, pen, pwr, sel;
    logic [AW-1:0]    padr;
    logic [DW-1:0]    pwd;
    logic [NR*DW-1:0] status0, status1, regq0, regq1;
    logic [7:0]       ecnt0, ecnt1;

    apb_slave_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb_slave_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.pselx   = psel & ~sel;
    assign bus0.penable = pen;
    assign bus0.pwrite  = pwr;
    assign bus0.paddr   = padr;
    assign bus0.pwdata  = pwd;
    assign bus1.pselx   = psel & sel;
    assign bus1.penable = pen;
    assign bus1.pwrite  = pwr;
    assign bus1.paddr   = padr;
    assign bus1.pwdata  = pwd;

    apb_slave_regbank #(.WAIT_STATES(0)) u_dut0 (
        .pclk     (pclk),
        .preset   (preset),
        .bus      (bus0),
        .status_i (status0),
        .reg_q    (regq0),
        .err_cnt  (ecnt0)
    );

    apb_slave_regbank #(.WAIT_STATES(2)) u_dut1 (
        .pclk     (pclk),
        .preset   (preset),
        .bus      (bus1),
        .status_i (status1),
        .reg_q    (regq1),
        .err_cnt  (ecnt1)
    );

    logic             rdy, perr;
    logic [DW-1:0]    prd;
    logic [7:0]       ecnt_obs;
    logic [NR*DW-1:0] regq_obs;
    assign rdy      = sel ? bus1.pready : bus0.pready;
    assign perr     = sel ? bus1.pslave_error : bus0.pslave_error;
    assign prd      = sel ? bus1.prdata : bus0.prdata;
    assign ecnt_obs = sel ? ecnt1 : ecnt0;
    assign regq_obs = sel ? regq1 : regq0;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mreg [2][8];
    int          mcnt [2];
    exp_t        exp_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [255:0] exp_regq(input logic s);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : mreg[s][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mcnt[s] = 0;
            for (int i = 0; i < 8; i++) mreg[s][i] = 32'h0;
        end
    endtask

    // Entered #1 after an edge; leaves #1 after the completion edge so calls chain
    // back-to-back with no idle cycle.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        exp_t             e;
        int               idx;
        int               waited;
        logic             err;
        logic [NR*DW-1:0] st;
        idx = int'(addr[7:2]);
        st  = sel ? status1 : status0;
        err = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && RO[idx[2:0]]);
        e.err   = err;
        e.waits = sel ? 2 : 0;
        if (err) e.rdata = 32'h0;
        else if (RO[idx[2:0]]) e.rdata = st[idx*32 +: 32];
        else e.rdata = mreg[sel][idx];
        exp_q.push_back(e);

        psel = 1'b1; pen = 1'b0; pwr = wr; padr = addr; pwd = data;
        @(posedge pclk); #1;
        pen    = 1'b1;
        waited = 0;
        while (!rdy && waited < 20) begin
            @(posedge pclk); #1;
            waited++;
        end
        e = exp_q.pop_front();
        check("pready", rdy, 1);
        check("wait_cycles", waited, e.waits);
        check("pslave_error", perr, e.err);
        if (!wr) check("prdata", prd, e.rdata);
        if (!err && wr) mreg[sel][idx] = data;
        if (err && mcnt[sel] < 255) mcnt[sel]++;

        @(posedge pclk); #1;
        psel = 1'b0; pen = 1'b0;
        check("idle_pready", rdy, 0);
        check("idle_prdata", prd, 0);
        check("err_cnt", ecnt_obs, mcnt[sel]);
        check("reg_q", regq_obs, exp_regq(sel));
    endtask

    initial begin
        model_reset();
        preset = 1'b1; psel = 1'b0; pen = 1'b0; pwr = 1'b0; padr = '0; pwd = '0; sel = 1'b0;
        status0 = '0;
        status0[255:224] = 32'h1234_5678;
        status0[223:192] = 32'hCAFE_0006;
        status1 = {8{32'h5A5A_0001}};
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b0;
        check("rst_pready0", bus0.pready, 0);
        check("rst_perr0", bus0.pslave_error, 0);
        check("rst_prdata0", bus0.prdata, 0);
        check("rst_errcnt0", ecnt0, 0);
        check("rst_regq0", regq0, 0);
        check("rst_pready1", bus1.pready, 0);
        check("rst_regq1", regq1, 0);

        // Zero-wait write then read
        xfer(1'b1, 8'h04, 32'hDEAD_BEEF);
        check("t1_regq", regq0[63:32], 32'hDEAD_BEEF);
        xfer(1'b0, 8'h04, 32'h0);

        // Two wait states, read of reset value
        sel = 1'b1;
        xfer(1'b0, 8'h00, 32'h0);
        xfer(1'b1, 8'h0C, 32'h0BAD_F00D);
        xfer(1'b0, 8'h0C, 32'h0);
        xfer(1'b0, 8'h1C, 32'h0);
        sel = 1'b0;

        // Read-only status reads
        xfer(1'b0, 8'h1C, 32'h0);
        xfer(1'b0, 8'h18, 32'h0);

        // Error paths
        xfer(1'b1, 8'h18, 32'h1111_1111);
        xfer(1'b1, 8'h21, 32'h2222_2222);
        xfer(1'b1, 8'h40, 32'h3333_3333);
        check("t3_errcnt", ecnt0, 3);

        // Abort in WAIT on the two-wait instance
        sel = 1'b1;
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; padr = 8'h08; pwd = 32'h0000_0055;
        @(posedge pclk); #1;
        pen = 1'b1;
        check("abort_wait_lo", rdy, 0);
        @(posedge pclk); #1;
        psel = 1'b0; pen = 1'b0;
        @(posedge pclk); #1;
        check("abort_pready", rdy, 0);
        check("abort_errcnt", ecnt1, mcnt[1]);
        xfer(1'b0, 8'h08, 32'h0);
        sel = 1'b0;

        // Back-to-back writes then reads
        for (int i = 0; i < 6; i++) xfer(1'b1, 8'(i * 4), 32'h1000_0000 + 32'(i) * 32'h111);
        for (int i = 0; i < 6; i++) xfer(1'b0, 8'(i * 4), 32'h0);

        // Reset coinciding with write completion
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; padr = 8'h08; pwd = 32'h0000_00A5;
        @(posedge pclk); #1;
        pen = 1'b1;
        check("rst_ready_hi", rdy, 1);
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; pen = 1'b0;
        model_reset();
        check("rst_mid_pready", bus0.pready, 0);
        check("rst_mid_reg2", regq0[95:64], 32'h0);
        check("rst_mid_errcnt", ecnt0, 0);
        check("rst_mid_regq1", regq1, 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            if (i[0]) xfer(1'b0, 8'h21, 32'h0);
            else xfer(1'b1, 8'h40, 32'(i));
        end
        check("sat_errcnt", ecnt0, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
